// File: rtl/vrf_pkg.sv
// Shared types for the vector register file: command opcodes and sequencer states.
package vrf_pkg;

  typedef enum logic [1:0] {
    VRF_WRITE = 2'b00,
    VRF_READ  = 2'b01,
    VRF_ALU   = 2'b10,
    VRF_RSVD  = 2'b11
  } vrf_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } vrf_state_e;

endpackage

// File: rtl/vrf_seq.sv
// Command accept and ALU dispatch/write-back sequencer; all handshake outputs are
// registered so no input reaches cmd_ready, alu_valid or rd_valid combinationally.
module vrf_seq
  import vrf_pkg::*;
#(
  parameter int RAW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  input  logic [1:0]     cmd_op,
  input  logic [RAW-1:0] cmd_rd,
  input  logic [RAW-1:0] cmd_rd2,
  input  logic           alu_ready,
  input  logic           res_valid,
  output logic           cmd_ready,
  output logic           alu_valid,
  output logic           busy,
  output logic           rd_valid,
  output logic           acc_write,
  output logic           acc_read,
  output logic           acc_alu,
  output logic           wb_en,
  output logic [RAW-1:0] wb_rd,
  output logic [RAW-1:0] wb_rd2
);

  vrf_state_e     state_q;
  logic           ready_q;
  logic           alu_valid_q;
  logic           busy_q;
  logic           rd_valid_q;
  logic [RAW-1:0] wb_rd_q;
  logic [RAW-1:0] wb_rd2_q;
  logic           accept;
  vrf_op_e        op;

  assign op        = vrf_op_e'(cmd_op);
  assign accept    = cmd_valid & ready_q;
  assign acc_write = accept & (op == VRF_WRITE);
  assign acc_read  = accept & (op == VRF_READ);
  assign acc_alu   = accept & (op == VRF_ALU);
  // Results outside WAIT are dropped; reset gating is done by the register array.
  assign wb_en     = (state_q == ST_WAIT) & res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      alu_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_rd2_q    <= '0;
    end else begin
      rd_valid_q <= acc_read;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (acc_alu) begin
            state_q     <= ST_ISSUE;
            ready_q     <= 1'b0;
            alu_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            wb_rd_q     <= cmd_rd;
            wb_rd2_q    <= cmd_rd2;
          end
        end
        ST_ISSUE: begin
          if (alu_ready) begin
            state_q     <= ST_WAIT;
            alu_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          ready_q     <= 1'b0;
          alu_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign alu_valid = alu_valid_q;
  assign busy      = busy_q;
  assign rd_valid  = rd_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_rd2    = wb_rd2_q;

endmodule

// File: rtl/vrf_bank.sv
// Vector register file with READ/WRITE commands and ALU operand dispatch and write-back.
// Optional per-element write mask on WRITE when VRF_WMASK_EN is defined.
module vrf_bank
  import vrf_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int VLEN     = 512,
  parameter int ELEM_W   = 32,
  localparam int NELEM   = VLEN / ELEM_W,
  localparam int RAW     = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [RAW-1:0]           cmd_rd,
  input  logic [RAW-1:0]           cmd_rd2,
  input  logic [RAW-1:0]           cmd_rs1,
  input  logic [RAW-1:0]           cmd_rs2,
  input  logic [VLEN-1:0]          cmd_wdata,
`ifdef VRF_WMASK_EN
  input  logic [NELEM-1:0]         cmd_wmask,
`endif
  output logic                     rd_valid,
  output logic [VLEN-1:0]          rd_data,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [VLEN-1:0]          alu_a,
  output logic [VLEN-1:0]          alu_b,
  input  logic                     res_valid,
  input  logic [VLEN-1:0]          res_lo,
  input  logic [VLEN-1:0]          res_hi,
  output logic                     busy,
  output logic [NUM_REGS*VLEN-1:0] dbg_regs
);

  logic [VLEN-1:0] regs_q [NUM_REGS];
  logic [VLEN-1:0] rd_data_q;
  logic [VLEN-1:0] alu_a_q;
  logic [VLEN-1:0] alu_b_q;
  logic [VLEN-1:0] wr_val;
  logic            acc_write;
  logic            acc_read;
  logic            acc_alu;
  logic            wb_en;
  logic [RAW-1:0]  wb_rd;
  logic [RAW-1:0]  wb_rd2;

  vrf_seq #(.RAW(RAW)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rd2   (cmd_rd2),
    .alu_ready (alu_ready),
    .res_valid (res_valid),
    .cmd_ready (cmd_ready),
    .alu_valid (alu_valid),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .acc_write (acc_write),
    .acc_read  (acc_read),
    .acc_alu   (acc_alu),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_rd2    (wb_rd2)
  );

`ifdef VRF_WMASK_EN
  always_comb begin
    wr_val = regs_q[cmd_rd];
    for (int e = 0; e < NELEM; e++) begin
      if (cmd_wmask[e]) wr_val[e*ELEM_W +: ELEM_W] = cmd_wdata[e*ELEM_W +: ELEM_W];
    end
  end
`else
  assign wr_val = cmd_wdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      rd_data_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
    end else begin
      if (acc_write) regs_q[cmd_rd] <= wr_val;
      // Second assignment takes precedence, so res_hi wins when rd == rd2.
      if (wb_en) begin
        regs_q[wb_rd]  <= res_lo;
        regs_q[wb_rd2] <= res_hi;
      end
      if (acc_read) rd_data_q <= regs_q[cmd_rs1];
      if (acc_alu) begin
        alu_a_q <= regs_q[cmd_rs1];
        alu_b_q <= regs_q[cmd_rs2];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
    assign dbg_regs[g*VLEN +: VLEN] = regs_q[g];
  end

endmodule

// File: doc/vrf_bank.md
# vrf_bank

Parametrised vector register file with a command handshake and an ALU dispatch/write-back sequencer. It replaces the fixed four-register, delay-driven design with NUM_REGS registers of VLEN bits and valid/ready handshakes on every path. It sits between the vector control unit (commands) and the vector ALU (operands and results), and it exposes all registers on a flat debug bus for the bench.

## Interface
- NUM_REGS, 4: number of vector registers (power of two, at least 2)
- VLEN, 512: register width in bits
- ELEM_W, 32: element width; VLEN must be a multiple of ELEM_W; NELEM = VLEN/ELEM_W
- RAW, $clog2(NUM_REGS): register-index width (derived)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 WRITE, 01 READ, 10 ALU, 11 reserved (accepted, no effect)
- cmd_rd  in  RAW  WRITE target; ALU first destination
- cmd_rd2  in  RAW  ALU second destination
- cmd_rs1  in  RAW  READ source; ALU operand A
- cmd_rs2  in  RAW  ALU operand B
- cmd_wdata  in  VLEN  WRITE data
- cmd_wmask  in  NELEM  per-element write enable (present only with VRF_WMASK_EN)
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_data  out  VLEN  READ result; holds until the next READ
- alu_valid  out  1  operands offered to the ALU
- alu_ready  in  1  ALU accepts the operands
- alu_a, alu_b  out  VLEN  operands
- res_valid  in  1  ALU result present
- res_lo, res_hi  in  VLEN  results; res_lo is written to rd, res_hi to rd2
- busy  out  1  high whenever the state is not IDLE
- dbg_regs  out  NUM_REGS*VLEN  register r occupies bits [r*VLEN +: VLEN]

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- A command is accepted on a rising edge where cmd_valid and cmd_ready are both high.
- WRITE, accepted in IDLE:
  - regs[cmd_rd] is updated at the accepting edge.
  - The FSM stays in IDLE.
- READ, accepted in IDLE:
  - rd_data <= regs[cmd_rs1] at the accepting edge, with rd_valid = 1 for the following cycle.
  - The FSM stays in IDLE.
- ALU, accepted in IDLE:
  - At the accepting edge: alu_a <= regs[cmd_rs1], alu_b <= regs[cmd_rs2]; rd and rd2 are latched; the FSM goes to ISSUE.
- ISSUE:
  - alu_valid = 1; alu_a and alu_b are held stable.
  - Goes to WAIT on the edge where alu_ready is high.
- WAIT:
  - alu_valid = 0.
  - On the edge where res_valid is high: regs[rd] <= res_lo, regs[rd2] <= res_hi, FSM goes to IDLE.
  - If rd == rd2, res_hi wins.
- res_valid outside WAIT and alu_ready outside ISSUE are ignored.
- Reserved op: accepted with no state change.
- Reset: all registers, rd_data, alu_a and alu_b clear to 0; rd_valid, alu_valid and busy go to 0; cmd_ready goes to 1 in the cycle after reset deasserts.
- Reset asserted mid-operation aborts any ALU operation. Nothing is written back, and a late res_valid is ignored.

## Timing
- WRITE: new value visible on dbg_regs and to READ one cycle after the accepting edge. Back-to-back WRITE then READ of the same register returns the new value.
- READ latency is 1 cycle. READs can be issued every cycle.
- ALU operation, best case (alu_ready high in the first ISSUE cycle, res_valid high in the first WAIT cycle): accept at edge 0, alu_valid in cycle 1, write-back at edge 2, cmd_ready high again in cycle 3.
- Each wait cycle on alu_ready or res_valid adds exactly one cycle.
- No combinational path from any input to cmd_ready, alu_valid or rd_valid.

## Configuration
- VRF_WMASK_EN defined:
  - cmd_wmask port exists.
  - WRITE updates only elements e where cmd_wmask[e] = 1; other elements keep their value.
  - ALU write-back is always unmasked.
- VRF_WMASK_EN undefined:
  - No cmd_wmask port.
  - WRITE replaces the full register.

## Structure
- Package vrf_pkg holds:
  - the cmd_op enum (VRF_WRITE, VRF_READ, VRF_ALU, VRF_RSVD)
  - the FSM state enum
- Sub-module vrf_seq holds the FSM and the handshake logic. The register array and read muxes stay in vrf_bank.

## Test plan
- Reset, then WRITE r2 = 0xA5…A5, then READ r2: rd_valid pulses in the cycle after the READ is accepted, with rd_data = 0xA5…A5. dbg_regs shows the value; all other registers read 0.
- ALU with rs1 = r0 = 1 and rs2 = r1 = 2, rd = 2, rd2 = 3, alu_ready tied high, res_valid in the first WAIT cycle with lo = 3, hi = 7: r2 = 3 and r3 = 7; cmd_ready returns in cycle 3.
- ALU with alu_ready delayed 3 cycles and res_valid delayed 2 cycles: alu_a and alu_b stay stable throughout; busy lasts 7 cycles; cmd_valid held high during that time is not accepted.
- ALU with rd = rd2 = r1, lo = 0x11, hi = 0x22: r1 = 0x22.
- rst asserted in WAIT, then res_valid pulsed: all registers are 0, no write-back occurs, state is IDLE.
- With VRF_WMASK_EN: r0 = all ones, then WRITE r0 = 0 with mask = 0b…0101: only elements 0 and 2 are cleared.
